// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared constants, state type and normalisation helper for corr_multi_window
// Ports: none (package).
// Macro CORR_MULTI_WINDOW_CHECKSUM_EN appends a trailing XOR checksum byte to every packet.
package corr_pkg;

    localparam int DEF_MAX_EXP      = 16;
    localparam int DEF_RESULT_BYTES = 1;

`ifdef CORR_MULTI_WINDOW_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    // Packet field order on the wire
    localparam int FLD_WINNUM  = 0;
    localparam int FLD_X       = 1;
    localparam int FLD_Y       = 2;
    localparam int FLD_ISECT   = 3;
    localparam int FLD_SYMDIFF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    function automatic int cnt_w(input int max_exp);
        return max_exp + 1;
    endfunction

    function automatic int pkt_len(input int result_bytes);
        return 1 + 4 * result_bytes + CSUM_BYTES;
    endfunction

    localparam int CNT_W   = cnt_w(DEF_MAX_EXP);
    localparam int PKT_LEN = pkt_len(DEF_RESULT_BYTES);

    // A full window (2^l) lands on 2^max_exp, i.e. the MSB of the reported field.
    function automatic logic [31:0] normalise(input logic [31:0] snap, input int max_exp,
                                              input int l, input int result_bytes);
        return (snap << (max_exp - l)) >> (max_exp + 1 - 8 * result_bytes);
    endfunction

endpackage

// File: rtl/corr_multi_window_if.sv
// rtl/corr_multi_window_if.sv - byte valid/ready packet stream
// Signals: o_data (packet byte), o_valid (byte valid), i_ready (byte accepted).
interface corr_multi_window_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/corr_pkt_serializer.sv
// rtl/corr_pkt_serializer.sv - packet register, IDLE/SEND FSM and drop counter
// Ports: i_clk, i_rst (sync, active-high), i_cg (clock-gate enable), i_load (new packet),
//        i_pkt (packet, byte 0 in LSBs), stream (byte master), o_nDropped (saturating drops).
module corr_pkt_serializer #(
    parameter int PKT_LEN = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cg,
    input  logic                   i_load,
    input  logic [8*PKT_LEN-1:0]   i_pkt,
    corr_multi_window_if.master    stream,
    output logic [7:0]             o_nDropped
);
    import corr_pkg::ser_state_t;
    import corr_pkg::ST_IDLE;
    import corr_pkg::ST_SEND;

    localparam int IDX_W = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(PKT_LEN - 1);

    ser_state_t       state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [7:0]       pkt [PKT_LEN];
    logic [7:0]       n_drop;
    logic             hs, load_pkt, drop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            n_drop <= '0;
            for (int i = 0; i < PKT_LEN; i++) pkt[i] <= '0;
        end else if (i_cg) begin
            state <= state_nx;
            idx   <= idx_nx;
            if (load_pkt) begin
                for (int i = 0; i < PKT_LEN; i++) pkt[i] <= i_pkt[8*i +: 8];
            end
            if (drop && n_drop != 8'hFF) n_drop <= n_drop + 8'd1;
        end
    end

    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        load_pkt       = 1'b0;
        drop           = 1'b0;
        hs             = i_cg && (state == ST_SEND) && stream.i_ready;
        stream.o_valid = (state == ST_SEND);
        stream.o_data  = (state == ST_SEND) ? pkt[idx] : 8'h00;
        case (state)
            ST_IDLE: begin
                if (i_load) begin
                    load_pkt = 1'b1;
                    idx_nx   = '0;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs && idx == LAST) begin
                    idx_nx = '0;
                    // A wrap landing on the final handshake chains straight into the next packet.
                    if (i_load) load_pkt = 1'b1;
                    else        state_nx = ST_IDLE;
                end else begin
                    if (hs)     idx_nx = idx + 1'b1;
                    if (i_load) drop   = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign o_nDropped = n_drop;

endmodule

// File: rtl/corr_multi_window.sv
// rtl/corr_multi_window.sv - multi-window X/Y correlator with packetised byte output
// Ports: i_clk, i_rst (sync, active-high), i_cg (clock-gate enable), i_strobe (sample strobe),
//        i_ch (channel samples), i_xSel/i_ySel (pair select), i_windowLengthExp (L),
//        stream (byte valid/ready master), o_nDropped (saturating dropped-packet count).
// Macro CORR_MULTI_WINDOW_CHECKSUM_EN appends an XOR checksum byte to each packet.
module corr_multi_window
    import corr_pkg::*;
#(
    parameter int N_CH                  = 4,
    parameter int MAX_WINDOW_LENGTH_EXP = DEF_MAX_EXP,
    parameter int RESULT_BYTES          = DEF_RESULT_BYTES
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_cg,
    input  logic                                     i_strobe,
    input  logic [N_CH-1:0]                          i_ch,
    input  logic [$clog2(N_CH)-1:0]                  i_xSel,
    input  logic [$clog2(N_CH)-1:0]                  i_ySel,
    input  logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0] i_windowLengthExp,
    corr_multi_window_if.master                      stream,
    output logic [7:0]                               o_nDropped
);
    localparam int CNT_BITS  = cnt_w(MAX_WINDOW_LENGTH_EXP);
    localparam int PKT_BYTES = pkt_len(RESULT_BYTES);
    localparam int FW        = 8 * RESULT_BYTES;
    localparam int SEL_W     = $clog2(N_CH);
    localparam int LEN_W     = $clog2(MAX_WINDOW_LENGTH_EXP + 1);
    localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_WINDOW_LENGTH_EXP);

    logic [SEL_W-1:0]    xsel, ysel;
    logic [LEN_W-1:0]    len, len_in;
    logic [CNT_BITS-2:0] t, mask;
    logic [CNT_BITS-1:0] cnt  [FLD_X:FLD_SYMDIFF];
    logic [CNT_BITS-1:0] inc  [FLD_X:FLD_SYMDIFF];
    logic [CNT_BITS-1:0] snap [FLD_X:FLD_SYMDIFF];
    logic [7:0]          win_num;
    logic                s, x, y, wrap;
    logic [8*PKT_BYTES-1:0] pkt;

    assign len_in = (i_windowLengthExp > L_MAX) ? L_MAX : i_windowLengthExp;
    assign s      = i_cg && i_strobe;
    assign x      = i_ch[xsel];
    assign y      = i_ch[ysel];
    // Low L bits of t all ones marks the last sample; L=0 gives an empty mask, so every sample wraps.
    assign mask   = ~({(CNT_BITS-1){1'b1}} << len);
    assign wrap   = s && ((t & mask) == mask);

    assign inc[FLD_X]       = CNT_BITS'(x);
    assign inc[FLD_Y]       = CNT_BITS'(y);
    assign inc[FLD_ISECT]   = CNT_BITS'(x & y);
    assign inc[FLD_SYMDIFF] = CNT_BITS'(x ^ y);

    always_comb begin
        for (int f = FLD_X; f <= FLD_SYMDIFF; f++) snap[f] = cnt[f] + inc[f];
    end

    always_comb begin
        pkt = '0;
        pkt[8*FLD_WINNUM +: 8] = win_num;
        for (int f = FLD_X; f <= FLD_SYMDIFF; f++) begin
            pkt[8*(1 + (f - FLD_X)*RESULT_BYTES) +: FW] =
                FW'(normalise(32'(snap[f]), MAX_WINDOW_LENGTH_EXP, int'(len), RESULT_BYTES));
        end
`ifdef CORR_MULTI_WINDOW_CHECKSUM_EN
        for (int b = 0; b < PKT_BYTES - 1; b++) begin
            pkt[8*(PKT_BYTES-1) +: 8] = pkt[8*(PKT_BYTES-1) +: 8] ^ pkt[8*b +: 8];
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            t       <= '0;
            win_num <= '0;
            xsel    <= i_xSel;
            ysel    <= i_ySel;
            len     <= len_in;
            for (int f = FLD_X; f <= FLD_SYMDIFF; f++) cnt[f] <= '0;
        end else if (s) begin
            if (wrap) begin
                // Config only takes effect at a window boundary so a window is never mixed.
                t       <= '0;
                win_num <= win_num + 8'd1;
                xsel    <= i_xSel;
                ysel    <= i_ySel;
                len     <= len_in;
                for (int f = FLD_X; f <= FLD_SYMDIFF; f++) cnt[f] <= '0;
            end else begin
                t <= t + 1'b1;
                for (int f = FLD_X; f <= FLD_SYMDIFF; f++) cnt[f] <= snap[f];
            end
        end
    end

    corr_pkt_serializer #(
        .PKT_LEN (PKT_BYTES)
    ) u_ser (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cg       (i_cg),
        .i_load     (wrap),
        .i_pkt      (pkt),
        .stream     (stream),
        .o_nDropped (o_nDropped)
    );

endmodule

// File: tb/tb_corr_multi_window.sv
// tb/tb_corr_multi_window.sv - self-checking bench for corr_multi_window
module tb_corr_multi_window;
    localparam int MAXE = 8;
`ifdef CORR_MULTI_WINDOW_CHECKSUM_EN
    localparam int PLEN = 6;
`else
    localparam int PLEN = 5;
`endif

    logic       clk = 1'b0;
    logic       rst, cg, strobe;
    logic [3:0] ch;
    logic [1:0] xs, ys;
    logic [3:0] len;
    logic [7:0] ndrop;

    corr_multi_window_if sif();

    corr_multi_window #(
        .N_CH(4), .MAX_WINDOW_LENGTH_EXP(MAXE), .RESULT_BYTES(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_strobe(strobe), .i_ch(ch),
        .i_xSel(xs), .i_ySel(ys), .i_windowLengthExp(len), .stream(sif), .o_nDropped(ndrop)
    );

    always #5 clk = ~clk;

    int total, bad, ph;
    int m_t, m_cx, m_cy, m_ci, m_cs, m_win, m_drop, m_rem, m_xs, m_ys, m_l;
    logic [7:0] q[$];
    logic [7:0] sent[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] nrm(input int c, input int l);
        return 8'((c << (MAXE - l)) >> (MAXE - 7));
    endfunction

    task automatic model_reset();
        m_t = 0; m_cx = 0; m_cy = 0; m_ci = 0; m_cs = 0;
        m_win = 0; m_drop = 0; m_rem = 0;
        q.delete(); sent.delete();
        m_xs = int'(xs); m_ys = int'(ys);
        m_l = (int'(len) > MAXE) ? MAXE : int'(len);
    endtask

    // One clock: check outputs mid-cycle, advance the reference model, return #1 after the edge.
    task automatic tick();
        logic hs, x, y;
        logic [7:0] b [PLEN];
        logic [7:0] cs;
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else begin
            check("valid", {31'b0, sif.o_valid}, {31'b0, m_rem > 0});
            check("ndrop", {24'b0, ndrop}, 32'(m_drop));
            if (m_rem > 0 && q.size() > 0) check("data", {24'b0, sif.o_data}, {24'b0, q[0]});
            hs = cg && sif.i_ready && (m_rem > 0);
            if (hs) begin
                sent.push_back(sif.o_data);
                if (q.size() > 0) void'(q.pop_front());
                m_rem--;
            end
            if (cg && strobe) begin
                x = ch[m_xs]; y = ch[m_ys];
                m_cx += int'(x); m_cy += int'(y); m_ci += int'(x & y); m_cs += int'(x ^ y);
                m_t++;
                if (m_t == (1 << m_l)) begin
                    b[0] = 8'(m_win); b[1] = nrm(m_cx, m_l); b[2] = nrm(m_cy, m_l);
                    b[3] = nrm(m_ci, m_l); b[4] = nrm(m_cs, m_l);
`ifdef CORR_MULTI_WINDOW_CHECKSUM_EN
                    cs = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
                    b[5] = cs;
`else
                    cs = 8'h00;
`endif
                    if (m_rem == 0) begin
                        for (int i = 0; i < PLEN; i++) q.push_back(b[i]);
                        m_rem = PLEN;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                    m_win = (m_win + 1) % 256;
                    m_t = 0; m_cx = 0; m_cy = 0; m_ci = 0; m_cs = 0;
                    m_xs = int'(xs); m_ys = int'(ys);
                    m_l = (int'(len) > MAXE) ? MAXE : int'(len);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // n cycles; strobe high for the first 'on' cycles of every 'period'.
    task automatic run(input int n, input int on, input int period);
        for (int k = 0; k < n; k++) begin
            strobe = (k % period) < on;
            ch = {1'($urandom), 1'b0, ~ph[0], 1'b1};
            if (strobe && cg) ph++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; strobe = 1'b0;
        tick();
        rst = 1'b0; ph = 0;
    endtask

    initial begin
        total = 0; bad = 0; ph = 0;
        rst = 1'b1; cg = 1'b1; strobe = 1'b0; ch = '0;
        xs = 2'd0; ys = 2'd1; len = 4'd3; sif.i_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_valid", {31'b0, sif.o_valid}, 32'd0);
        check("rst_data", {24'b0, sif.o_data}, 32'd0);
        check("rst_ndrop", {24'b0, ndrop}, 32'd0);

        // Basic packets, L=3, strobe every cycle
        run(40, 1, 1); run(10, 0, 1);
        check("a_count", sent.size(), 5 * PLEN);
        check("a_win0", {24'b0, sent[0]}, 32'h00);
        check("a_cx", {24'b0, sent[1]}, 32'h80);
        check("a_cy", {24'b0, sent[2]}, 32'h40);
        check("a_ci", {24'b0, sent[3]}, 32'h40);
        check("a_cs", {24'b0, sent[4]}, 32'h40);
        check("a_win1", {24'b0, sent[PLEN]}, 32'h01);
`ifdef CORR_MULTI_WINDOW_CHECKSUM_EN
        check("a_csum", {24'b0, sent[5]}, 32'hC0);
`endif

        // Stall: first packet held, two wraps dropped
        len = 4'd2; do_reset();
        sif.i_ready = 1'b0;
        run(12, 1, 1);
        check("b_ndrop", {24'b0, ndrop}, 32'd2);
        check("b_held", {24'b0, sif.o_data}, 32'h00);
        sif.i_ready = 1'b1;
        run(10, 0, 1); run(4, 1, 1); run(10, 0, 1);
        check("b_count", sent.size(), 2 * PLEN);
        check("b_gap", {24'b0, sent[PLEN]}, 32'h03);

        // Wrap coincides with last-byte handshake: back-to-back, no drop
        len = 4'd2; do_reset();
        run(8 * PLEN, 4, PLEN); run(10, 0, 1);
        check("c_b2b_count", sent.size(), 8 * PLEN);
        check("c_b2b_ndrop", {24'b0, ndrop}, 32'd0);

        // L=0, x=y=ch0, strobe every 6th cycle
        len = 4'd0; xs = 2'd0; ys = 2'd0; do_reset();
        run(48, 1, 6); run(10, 0, 1);
        check("d_count", sent.size(), 8 * PLEN);
        check("d_ndrop", {24'b0, ndrop}, 32'd0);
        check("d_cx", {24'b0, sent[1]}, 32'h80);
        check("d_ci", {24'b0, sent[3]}, 32'h80);
        check("d_cs", {24'b0, sent[4]}, 32'h00);

        // Mid-window X select change
        len = 4'd2; xs = 2'd0; ys = 2'd1; do_reset();
        run(2, 1, 1); xs = 2'd2; run(2, 1, 1);
        run(PLEN + 1, 0, 1); run(4, 1, 1); run(PLEN + 2, 0, 1);
        check("e_count", sent.size(), 2 * PLEN);
        check("e_cx_old", {24'b0, sent[1]}, 32'h80);
        check("e_cx_new", {24'b0, sent[PLEN + 1]}, 32'h00);

        // Reset while byte 2 is on the bus
        len = 4'd3; xs = 2'd0; ys = 2'd1; do_reset();
        run(8, 1, 1); run(2, 0, 1);
        check("f_pre", {24'b0, sif.o_data}, 32'h40);
        do_reset();
        check("f_valid", {31'b0, sif.o_valid}, 32'd0);
        check("f_ndrop", {24'b0, ndrop}, 32'd0);
        run(8, 1, 1); run(10, 0, 1);
        check("f_count", sent.size(), PLEN);
        check("f_win", {24'b0, sent[0]}, 32'h00);
        check("f_cx", {24'b0, sent[1]}, 32'h80);

        // Clock gate low mid-packet: nothing advances
        do_reset();
        run(8, 1, 1); run(1, 0, 1);
        cg = 1'b0;
        run(3, 1, 1);
        check("g_hold", {24'b0, sif.o_data}, 32'h80);
        check("g_valid", {31'b0, sif.o_valid}, 32'd1);
        cg = 1'b1;
        run(12, 0, 1);
        check("g_count", sent.size(), PLEN);
        check("g_cy", {24'b0, sent[2]}, 32'h40);
`ifdef CORR_MULTI_WINDOW_CHECKSUM_EN
        check("g_csum", {24'b0, sent[5]}, 32'hC0);
`endif

        // L above the maximum clamps to MAXE (256-sample window)
        len = 4'd12; do_reset();
        run(256, 1, 1); run(10, 0, 1);
        check("h_count", sent.size(), PLEN);
        check("h_cx", {24'b0, sent[1]}, 32'h80);
        check("h_cy", {24'b0, sent[2]}, 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
